// File: rtl/frog_pkg.sv
// Shared constants, tile/sink types and sink-sequencer helpers for the frog lane drawers.
// The sink helpers are only referenced when LOG_SINK_EN is defined.
package frog_pkg;

  localparam int SCREEN_W          = 640;
  localparam int TILE_SIZE_DEFAULT = 20;

  localparam logic [7:0] LOG_BODY = 8'h8C;
  localparam logic [7:0] LOG_BARK = 8'h64;

  typedef enum logic [1:0] {
    LEFT_END  = 2'd0,
    MIDDLE    = 2'd1,
    RIGHT_END = 2'd2
  } log_tile_t;

  typedef enum logic [1:0] {
    FLOAT   = 2'd0,
    SINKING = 2'd1,
    SUNK    = 2'd2,
    RISING  = 2'd3
  } sink_state_t;

  // Last frame index spent in each sink state (durations 96/16/32/16).
  function automatic logic [6:0] sink_last(input sink_state_t s);
    logic [6:0] last;
    last = 7'd95;
    case (s)
      FLOAT:   last = 7'd95;
      SINKING: last = 7'd15;
      SUNK:    last = 7'd31;
      RISING:  last = 7'd15;
    endcase
    return last;
  endfunction

  function automatic sink_state_t sink_next(input sink_state_t s);
    sink_state_t nxt;
    nxt = FLOAT;
    case (s)
      FLOAT:   nxt = SINKING;
      SINKING: nxt = SUNK;
      SUNK:    nxt = RISING;
      RISING:  nxt = FLOAT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/log_lane_draw_if.sv
// Pixel-stream and status bundle between the VGA timing/game logic and one log lane.
interface log_lane_draw_if;
  logic [10:0] oCoord_X;
  logic [10:0] oCoord_Y;
  logic        startOfFrame;
  logic        enable;
  logic [10:0] laneY;
  logic        drawing_request;
  logic [7:0]  mVGA_RGB;
  logic        lane_step;
  logic        log_solid;

  modport master (
    output oCoord_X, oCoord_Y, startOfFrame, enable, laneY,
    input  drawing_request, mVGA_RGB, lane_step, log_solid
  );

  modport slave (
    input  oCoord_X, oCoord_Y, startOfFrame, enable, laneY,
    output drawing_request, mVGA_RGB, lane_step, log_solid
  );
endinterface

// File: rtl/log_tile_rom.sv
// Combinational sprite lookup for one log tile: rounded-end mask and bark/body colour.
module log_tile_rom
  import frog_pkg::*;
#(
  parameter int TILE_SIZE = TILE_SIZE_DEFAULT,
  parameter int TW        = $clog2(TILE_SIZE)
) (
  input  log_tile_t       tile_kind,
  input  logic [TW-1:0]   x_t,
  input  logic [TW-1:0]   y_t,
  output logic            mask,
  output logic [7:0]      colour
);

  logic [TW-1:0] depth;
  logic [TW-1:0] cut;
  logic [TW-1:0] col;

  always_comb begin
    // depth = distance from the nearest horizontal edge, saturating at 4 (no cut)
    depth = TW'(4);
    if (y_t < TW'(4))                    depth = y_t;
    else if (y_t >= TW'(TILE_SIZE - 4))  depth = TW'(TILE_SIZE - 1) - y_t;
    cut    = TW'(4) - depth;
    col    = (tile_kind == RIGHT_END) ? TW'(TILE_SIZE - 1) - x_t : x_t;
    mask   = (tile_kind == MIDDLE) || (col >= cut);
    colour = (y_t < TW'(2) || y_t >= TW'(TILE_SIZE - 2)) ? LOG_BARK : LOG_BODY;
  end

endmodule

// File: rtl/log_lane_draw.sv
// One scrolling river lane of NUM_LOGS logs with a 2-stage pixel pipeline and wrap-around.
// Optional sink/rise cycle enabled by defining LOG_SINK_EN.
module log_lane_draw
  import frog_pkg::*;
#(
  parameter int NUM_LOGS      = 3,
  parameter int LOG_LEN_TILES = 3,
  parameter int TILE_SIZE     = TILE_SIZE_DEFAULT,
  parameter int LOG_SPACING   = 200,
  parameter int SPEED_DIV     = 2,
  parameter int STEP          = 1,
  parameter bit DIR_LEFT      = 1'b0
) (
  input  logic            CLK,
  input  logic            RESETn,
  log_lane_draw_if.slave  bus
);

  localparam int LOG_W = LOG_LEN_TILES * TILE_SIZE;
  localparam int TW    = $clog2(TILE_SIZE);
  localparam int FCW   = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(SPEED_DIV - 1);

  logic           move;
  logic [10:0]    offset;
  logic [10:0]    offset_next;
  logic [11:0]    sum;
  logic [FCW-1:0] frame_cnt;
  logic           lane_step_q;

  assign move = bus.startOfFrame && bus.enable;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sum         = {1'b0, offset} + 12'(STEP);
    offset_next = offset;
    if (DIR_LEFT) begin
      if (offset >= 11'(STEP)) offset_next = offset - 11'(STEP);
      else                     offset_next = offset + 11'(SCREEN_W - STEP);
    end else if (sum >= 12'(SCREEN_W)) begin
      offset_next = 11'(sum - 12'(SCREEN_W));
    end else begin
      offset_next = sum[10:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      offset      <= '0;
      frame_cnt   <= '0;
      lane_step_q <= 1'b0;
    end else begin
      lane_step_q <= 1'b0;
      if (move) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt   <= '0;
          offset      <= offset_next;
          lane_step_q <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + FCW'(1);
        end
      end
    end
  end

  // Stage 1: lane-relative position, log search and tile split by constant compares.
  logic            x_on_screen;
  logic [10:0]     x_rel;
  logic [10:0]     pos;
  logic            in_log_c;
  logic            in_lane_c;
  logic [7:0]      tile_c;
  logic [TW-1:0]   x_t_c;
  logic [TW-1:0]   y_t_c;
  logic [11:0]     y_end;
  log_tile_t       kind_c;

  always_comb begin
    x_on_screen = bus.oCoord_X < 11'(SCREEN_W);
    x_rel = (bus.oCoord_X >= offset) ? bus.oCoord_X - offset
                                     : bus.oCoord_X + 11'(SCREEN_W) - offset;
    in_log_c = 1'b0;
    pos      = '0;
    for (int k = 0; k < NUM_LOGS; k++) begin
      if (x_rel >= 11'(k * LOG_SPACING) && x_rel < 11'(k * LOG_SPACING + LOG_W)) begin
        in_log_c = 1'b1;
        pos      = x_rel - 11'(k * LOG_SPACING);
      end
    end
    if (!x_on_screen) in_log_c = 1'b0;

    tile_c = '0;
    x_t_c  = TW'(pos);
    for (int t = 1; t < LOG_LEN_TILES; t++) begin
      if (pos >= 11'(t * TILE_SIZE)) begin
        tile_c = 8'(t);
        x_t_c  = TW'(pos - 11'(t * TILE_SIZE));
      end
    end
    kind_c = MIDDLE;
    if (tile_c == 8'd0)                         kind_c = LEFT_END;
    else if (tile_c == 8'(LOG_LEN_TILES - 1))   kind_c = RIGHT_END;

    y_end     = {1'b0, bus.laneY} + 12'(TILE_SIZE);
    in_lane_c = (bus.oCoord_Y >= bus.laneY) && ({1'b0, bus.oCoord_Y} < y_end);
    y_t_c     = TW'(bus.oCoord_Y - bus.laneY);
  end

  logic          s1_in_lane;
  logic          s1_in_log;
  log_tile_t     s1_kind;
  logic [TW-1:0] s1_x_t;
  logic [TW-1:0] s1_y_t;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_in_lane <= 1'b0;
      s1_in_log  <= 1'b0;
      s1_kind    <= LEFT_END;
      s1_x_t     <= '0;
      s1_y_t     <= '0;
    end else begin
      s1_in_lane <= in_lane_c;
      s1_in_log  <= in_log_c;
      s1_kind    <= kind_c;
      s1_x_t     <= x_t_c;
      s1_y_t     <= y_t_c;
    end
  end

  logic       mask;
  logic [7:0] colour;

  log_tile_rom #(
    .TILE_SIZE (TILE_SIZE),
    .TW        (TW)
  ) u_rom (
    .tile_kind (s1_kind),
    .x_t       (s1_x_t),
    .y_t       (s1_y_t),
    .mask      (mask),
    .colour    (colour)
  );

  logic solid_q;
  logic draw_en;

`ifdef LOG_SINK_EN
  sink_state_t sink_state;
  logic [6:0]  sink_cnt;
  logic [6:0]  sink_cnt_inc;
  sink_state_t sink_nxt;

  assign sink_cnt_inc = sink_cnt + 7'd1;
  assign sink_nxt     = sink_next(sink_state);

  // Blinking in SINKING/RISING keys off bit 2 of the in-state frame count.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sink_state <= FLOAT;
      sink_cnt   <= '0;
      solid_q    <= 1'b1;
      draw_en    <= 1'b1;
    end else if (move) begin
      if (sink_cnt == sink_last(sink_state)) begin
        sink_state <= sink_nxt;
        sink_cnt   <= '0;
        solid_q    <= (sink_nxt == FLOAT);
        draw_en    <= (sink_nxt != SUNK);
      end else begin
        sink_cnt <= sink_cnt_inc;
        draw_en  <= (sink_state == FLOAT) ||
                    ((sink_state != SUNK) && !sink_cnt_inc[2]);
      end
    end
  end
`else
  assign solid_q = 1'b1;
  assign draw_en = 1'b1;
`endif

  logic       draw_q;
  logic [7:0] rgb_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      draw_q <= 1'b0;
      rgb_q  <= '0;
    end else begin
      draw_q <= s1_in_lane && s1_in_log && mask && draw_en;
      rgb_q  <= (s1_in_lane && s1_in_log) ? colour : 8'h00;
    end
  end

  assign bus.drawing_request = draw_q;
  assign bus.mVGA_RGB        = rgb_q;
  assign bus.lane_step       = lane_step_q;
  assign bus.log_solid       = solid_q;

endmodule

// File: tb/tb_log_lane_draw.sv
// Directed bench for log_lane_draw: reset, sprite boundaries, motion, wrap, mid-frame reset, sink cycle.
module tb_log_lane_draw;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  log_lane_draw_if bus ();
  log_lane_draw_if bus_l ();

  log_lane_draw u_dut (
    .CLK    (clk),
    .RESETn (rst_n),
    .bus    (bus.slave)
  );

  log_lane_draw #(
    .SPEED_DIV (1),
    .DIR_LEFT  (1'b1)
  ) u_dut_l (
    .CLK    (clk),
    .RESETn (rst_n),
    .bus    (bus_l.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int step_cnt = 0;

  always @(negedge clk) if (bus.lane_step === 1'b1) step_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one pixel to both lanes and check the selected lane two cycles later.
  task automatic pix(input bit left, input int x, input int y,
                     input bit exp_dr, input logic [7:0] exp_rgb, input string tag);
    @(negedge clk);
    bus.oCoord_X   = 11'(x);  bus.oCoord_Y   = 11'(y);
    bus_l.oCoord_X = 11'(x);  bus_l.oCoord_Y = 11'(y);
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (left) begin
      check({tag, "_dr"},  32'(bus_l.drawing_request), 32'(exp_dr));
      check({tag, "_rgb"}, 32'(bus_l.mVGA_RGB),        32'(exp_rgb));
    end else begin
      check({tag, "_dr"},  32'(bus.drawing_request), 32'(exp_dr));
      check({tag, "_rgb"}, 32'(bus.mVGA_RGB),        32'(exp_rgb));
    end
  endtask

  task automatic frame();
    @(negedge clk);
    bus.startOfFrame = 1'b1;  bus_l.startOfFrame = 1'b1;
    @(negedge clk);
    bus.startOfFrame = 1'b0;  bus_l.startOfFrame = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    bus.oCoord_X = '0;  bus.oCoord_Y = '0;  bus.startOfFrame = 1'b0;
    bus.enable = 1'b0;  bus.laneY = 11'd100;
    bus_l.oCoord_X = '0;  bus_l.oCoord_Y = '0;  bus_l.startOfFrame = 1'b0;
    bus_l.enable = 1'b0;  bus_l.laneY = 11'd100;
    repeat (3) @(negedge clk);
    check("rst_dr",     32'(bus.drawing_request), 32'd0);
    check("rst_rgb",    32'(bus.mVGA_RGB),        32'd0);
    check("rst_step",   32'(bus.lane_step),       32'd0);
    check("rst_solid",  32'(bus.log_solid),       32'd1);
    check("rst_offset", 32'(u_dut.offset),        32'd0);
    rst_n = 1'b1;

    // Sprite shape and lane boundaries at offset 0.
    pix(0,   0, 100, 1'b0, 8'h64, "corner_0_100");
    pix(0,   4, 100, 1'b1, 8'h64, "corner_4_100");
    pix(0,  10, 110, 1'b1, 8'h8C, "body_10_110");
    pix(0,  59, 110, 1'b1, 8'h8C, "right_end_59");
    pix(0,  60, 110, 1'b0, 8'h00, "gap_60");
    pix(0, 203, 119, 1'b0, 8'h64, "corner_203_119");
    pix(0, 204, 119, 1'b1, 8'h64, "log1_204_119");
    pix(0, 200, 120, 1'b0, 8'h00, "below_lane");
    pix(0, 200,  99, 1'b0, 8'h00, "above_lane");
    pix(0, 400, 102, 1'b0, 8'h8C, "corner_400_102");
    pix(0, 402, 102, 1'b1, 8'h8C, "log2_402_102");
    pix(0, 600, 110, 1'b0, 8'h00, "no_log3");
    pix(0, 650, 110, 1'b0, 8'h00, "off_screen");

    // Motion: SPEED_DIV=2 -> one step every second enabled frame.
    bus.enable = 1'b1;
    frame();
    check("mv1_steps",  32'(step_cnt),        32'd0);
    check("mv1_fcnt",   32'(u_dut.frame_cnt), 32'd1);
    check("mv1_offset", 32'(u_dut.offset),    32'd0);
    frame();
    check("mv2_steps",  32'(step_cnt),        32'd1);
    check("mv2_offset", 32'(u_dut.offset),    32'd1);
    check("mv2_fcnt",   32'(u_dut.frame_cnt), 32'd0);
    pix(0,  0, 110, 1'b0, 8'h00, "mv_x0");
    pix(0, 60, 110, 1'b1, 8'h8C, "mv_x60");
    pix(0,  1, 110, 1'b1, 8'h8C, "mv_x1");

    // Frame pulse coincident with a pixel: that pixel still sees the old offset.
    frame();
    @(negedge clk);
    bus.oCoord_X = 11'd61;  bus.oCoord_Y = 11'd110;  bus.startOfFrame = 1'b1;
    @(negedge clk);
    bus.oCoord_X = 11'd0;   bus.oCoord_Y = 11'd0;    bus.startOfFrame = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("coincident_dr", 32'(bus.drawing_request), 32'd0);
    check("coincident_offset", 32'(u_dut.offset), 32'd2);
    pix(0, 61, 110, 1'b1, 8'h8C, "after_move_61");

    bus.enable = 1'b0;
    repeat (5) frame();
    check("hold_offset", 32'(u_dut.offset),    32'd2);
    check("hold_fcnt",   32'(u_dut.frame_cnt), 32'd0);
    check("hold_steps",  32'(step_cnt),        32'd2);

    // Left-moving lane: 0 -> 639, and a log drawn continuously across 639/0.
    bus_l.enable = 1'b1;
    frame();
    bus_l.enable = 1'b0;
    check("left_wrap_offset", 32'(u_dut_l.offset), 32'd639);
    pix(1, 639, 110, 1'b1, 8'h8C, "seam_639");
    pix(1,   0, 110, 1'b1, 8'h8C, "seam_0");
    pix(1,  58, 110, 1'b1, 8'h8C, "seam_58");
    pix(1,  59, 110, 1'b0, 8'h00, "seam_59");
    pix(1, 599, 110, 1'b0, 8'h00, "seam_599");

    // Right-moving lane wrap: offset 2 -> 639 -> 0.
    bus.enable = 1'b1;
    repeat (1274) frame();
    check("right_639_offset", 32'(u_dut.offset), 32'd639);
    check("right_639_steps",  32'(step_cnt),     32'd639);
    repeat (2) frame();
    check("right_wrap_offset", 32'(u_dut.offset), 32'd0);
    check("right_wrap_steps",  32'(step_cnt),     32'd640);
    bus.enable = 1'b0;

    // Asynchronous reset while pixels stream.
    @(negedge clk);
    bus.oCoord_X = 11'd10;  bus.oCoord_Y = 11'd110;
    bus.enable = 1'b1;
    frame();
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_rgb", 32'(bus.mVGA_RGB), 32'h8C);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_dr",    32'(bus.drawing_request), 32'd0);
    check("mid_rst_rgb",   32'(bus.mVGA_RGB),        32'd0);
    check("mid_rst_solid", 32'(bus.log_solid),       32'd1);
    check("mid_rst_fcnt",  32'(u_dut.frame_cnt),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_offset", 32'(u_dut.offset),    32'd0);
    check("post_rst_fcnt",   32'(u_dut.frame_cnt), 32'd0);
    pix(0, 10, 110, 1'b1, 8'h8C, "post_rst_pix");

    // Sink cycle (offset advances 1 px per 2 enabled frames, so probe at offset+10).
    bus.enable = 1'b1;
    repeat (95) frame();
    check("f95_solid", 32'(bus.log_solid), 32'd1);
    frame();
    check("f96_offset", 32'(u_dut.offset), 32'd48);
`ifdef LOG_SINK_EN
    check("f96_solid", 32'(bus.log_solid), 32'd0);
`else
    check("f96_solid", 32'(bus.log_solid), 32'd1);
`endif
    pix(0, 58, 110, 1'b1, 8'h8C, "sinking_pix");
    repeat (16) frame();
    check("f112_offset", 32'(u_dut.offset), 32'd56);
`ifdef LOG_SINK_EN
    pix(0, 66, 110, 1'b0, 8'h8C, "sunk_end");
    pix(0, 86, 105, 1'b0, 8'h8C, "sunk_mid");
`else
    pix(0, 66, 110, 1'b1, 8'h8C, "sunk_end");
    pix(0, 86, 105, 1'b1, 8'h8C, "sunk_mid");
`endif
    repeat (48) frame();
    check("f160_offset", 32'(u_dut.offset), 32'd80);
    check("f160_solid",  32'(bus.log_solid), 32'd1);
    pix(0, 90, 110, 1'b1, 8'h8C, "float_again");
    bus.enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
